// File: rtl/matrix_mult_scheduler.sv
// Row-major sequencer for C = A*B: drives one shared inner_product unit through its
// strobe/ack handshake for every (row, col) pair and writes each result to the result store.
module matrix_mult_scheduler #(
   parameter int unsigned number_of_elements = 4,
   parameter int unsigned timeout_cycles     = 4096,
   localparam int unsigned IW = $clog2(number_of_elements),
   localparam int unsigned AW = $clog2(number_of_elements * number_of_elements)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [IW-1:0] row_idx,
   output logic [IW-1:0] col_idx,
   output logic          ip_row_stb,
   output logic          ip_column_stb,
   output logic          ip_out_ack,
   input  logic          ip_row_ack,
   input  logic          ip_column_ack,
   input  logic          ip_out_stb,
   input  logic [31:0]   ip_out,
   output logic          res_we,
   output logic [AW-1:0] res_addr,
   output logic [31:0]   res_data
);

   localparam int unsigned   TW          = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
   localparam logic [IW-1:0] LastIdx     = IW'(number_of_elements - 1);
   localparam logic [TW-1:0] TimeoutLast = TW'(timeout_cycles - 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StDrain, StDone} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] row_q, row_d, col_q, col_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic          err_q, err_d;
   logic          stb_q, stb_d;
   logic          we_q, we_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               row_d   = '0;
               col_d   = '0;
               err_d   = 1'b0;
               stb_d   = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            stb_d = 1'b1;
            if (ip_row_ack && ip_column_ack) begin
               stb_d   = 1'b0;
               cnt_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            if (ip_out_stb) begin
               data_d  = ip_out;
               we_d    = 1'b1;
               state_d = StWrite;
            end else if (cnt_q == TimeoutLast) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWrite: state_d = StDrain;
         StDrain: begin
            // Held until both acks fall so a stale ack cannot accept the next pair.
            if (!ip_row_ack && !ip_column_ack) begin
               if (col_q < LastIdx) begin
                  col_d   = col_q + 1'b1;
                  stb_d   = 1'b1;
                  state_d = StIssue;
               end else if (row_q < LastIdx) begin
                  col_d   = '0;
                  row_d   = row_q + 1'b1;
                  stb_d   = 1'b1;
                  state_d = StIssue;
               end else begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
         stb_d   = 1'b0;
         we_d    = 1'b0;
         done_d  = 1'b0;
      end

      busy_d = (state_d != StIdle);
      addr_d = AW'(row_d) * AW'(number_of_elements) + AW'(col_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         row_q   <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = err_q;
   assign row_idx       = row_q;
   assign col_idx       = col_q;
   assign ip_row_stb    = stb_q;
   assign ip_column_stb = stb_q;
   assign ip_out_ack    = stb_q;
   assign res_we        = we_q;
   assign res_addr      = addr_q;
   assign res_data      = data_q;

endmodule

// File: doc/matrix_mult_scheduler.md
# matrix_mult_scheduler

Sequencer that computes an N×N matrix product C = A·B with one shared `inner_product` unit. It steps through every (row, column) index pair in row-major order and drives the unit's strobe/ack handshake for each pair. Each finished 32-bit result is written to a result store. The block sits between the operand stores (A rows, B columns, addressed by `row_idx` and `col_idx`) and the `inner_product` instance; the operand vectors go directly from the stores to the unit, not through this block.

## Interface
Parameters:
- `number_of_elements`, 4: matrix dimension N, with N ≥ 2. The same value is used by the attached `inner_product`.
- `timeout_cycles`, 4096: maximum number of cycles allowed in WAIT before the operation is aborted with an error.

Derived widths: IW = $clog2(N), AW = $clog2(N*N).

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: start request; sampled only in IDLE.
- `abort` input 1: cancels the current operation.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse when all N² results have been written.
- `error` output 1: sticky timeout flag; cleared when the next `start` is accepted.
- `row_idx` output IW: A-row select for the operand store.
- `col_idx` output IW: B-column select for the operand store.
- `ip_row_stb` output 1: drives the unit's `row_i_stb`.
- `ip_column_stb` output 1: drives the unit's `column_i_stb`.
- `ip_out_ack` output 1: drives the unit's `out_o_ack`.
- `ip_row_ack` input 1: from the unit's `row_i_ack`.
- `ip_column_ack` input 1: from the unit's `column_i_ack`.
- `ip_out_stb` input 1: from the unit's `out_o_stb`.
- `ip_out` input 32: from the unit's `out`.
- `res_we` output 1: result write enable, a one-cycle pulse.
- `res_addr` output AW: result address, equal to row_idx*N + col_idx.
- `res_data` output 32: registered copy of `ip_out`.

## Operation
States:
- **IDLE**: strobes low. `start`=1 → clear the indices, clear `error`, go to ISSUE.
- **ISSUE**: `ip_row_stb`, `ip_column_stb` and `ip_out_ack` are all high. When `ip_row_ack` and `ip_column_ack` are both high → drop all three strobes, clear the timeout counter, go to WAIT.
- **WAIT**: strobes low.
  - `ip_out_stb`=1 → register `ip_out` into `res_data`, go to WRITE.
  - Otherwise the timeout counter increments. When it reaches `timeout_cycles`-1 → set `error`, go to IDLE. No write and no `done` are produced.
- **WRITE**: `res_we`=1 for exactly one cycle, with `res_addr`/`res_data` valid. The block then stays in DRAIN.
- **DRAIN**: wait until `ip_row_ack` and `ip_column_ack` are both low, so that a stale ack is never taken as acceptance of the next pair. Then advance the indices:
  - If col_idx < N-1 → col_idx+1, go to ISSUE.
  - Else if row_idx < N-1 → col_idx=0, row_idx+1, go to ISSUE.
  - Else → go to DONE.
- **DONE**: `done`=1 for one cycle, then go to IDLE. The indices are left at N-1/N-1.

Rules:
- `row_idx`/`col_idx` are held constant from ISSUE entry until DRAIN exit. The unit reads its operands continuously during the computation, so the indices must not change while it works.
- `abort`=1 in any state other than IDLE → go to IDLE on the next edge. All strobes drop, any pending write is cancelled, `done` is not pulsed, `error` is unchanged. A later `ip_out_stb` arriving in IDLE is ignored.
- `start` while busy is ignored.
- `start` and `abort` both high in IDLE → `abort` wins and the block stays in IDLE.
- `ip_out_stb` seen in ISSUE or DRAIN is ignored.
- Address arithmetic is unsigned, computed as {row_idx, IW-bit} × N + col_idx in AW bits. The maximum address is N²-1, so it never wraps.

## Timing
- Reset values: state IDLE; `busy`, `done`, `error`, `res_we`, `ip_row_stb`, `ip_column_stb`, `ip_out_ack` = 0; `row_idx`, `col_idx`, `res_addr`, `res_data` = 0.
- Reset asserted mid-operation takes effect immediately and asynchronously. No write is issued.
- All outputs are registered.
- `start` sampled high at edge t → ISSUE from t+1, with the strobes high in cycle t+1.
- Ack pair sampled high at edge a → strobes low from a+1.
- `ip_out_stb` sampled at edge w → `res_we` high in cycle w+1. DRAIN occupies w+2 at minimum.
- Block overhead is therefore 4 cycles per element plus the unit's own latency.
- `done` is asserted the cycle after the final DRAIN exit. `busy` falls the cycle after `done`.

## Test plan
- **Full run:** N=2, with a behavioural unit model returning row_idx*10+col_idx after 5 cycles. → Writes (addr 0, 0), (1, 1), (2, 10), (3, 11), in that order, each `res_we` exactly one cycle. `done` pulses once, `error` stays 0.
- **Slow ack:** the model delays its acks by 3 cycles on the second element. → Strobes stay high until the acks arrive. `row_idx`/`col_idx` stay stable from ISSUE through DRAIN. Exactly 4 writes.
- **Stale ack:** the model holds its acks high for 2 cycles after `ip_out_stb`. → DRAIN holds for those 2 cycles. The next ISSUE does not advance to WAIT until a fresh ack arrives.
- **Timeout:** `timeout_cycles`=16 and the model never raises `ip_out_stb`. → `error`=1 after 16 WAIT cycles, block returns to IDLE, no `done`, no write. The next `start` clears `error`.
- **Abort during WAIT of element 2** (of the N=2 run). → 1 write only (addr 0), `busy` low one edge later, no `done`, and the late `ip_out_stb` is ignored.
- **Reset mid-run, then start held high with abort low.** → All outputs return to reset values immediately. The rerun produces the full 4-write sequence.
